// File: rtl/uart_rx.sv
// uart_rx: receive end of the 16-bit serial frame format
// (start "0", 16 data bits LSB first, stop "1", no parity).
// Samples the synchronized line at mid-bit, presents the assembled word with a
// one-cycle valid pulse and flags frames whose stop bit reads "0".
module uart_rx #(
    parameter int CLOKS_POR_BIT = 5209
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bitSerialEntrada,
    output logic [15:0] dadosRecebidos,
    output logic        dadosProntos,
    output logic        indicaRecepcao,
    output logic        erroDeQuadro
);

    typedef enum logic [2:0] {
        ESPERA,
        VERIFICA_INICIO,
        RECEBE_BITS,
        VERIFICA_FINAL,
        LIMPEZA
    } estado_t;

    localparam logic [12:0] MEIO_BIT = 13'((CLOKS_POR_BIT - 1) / 2);
    localparam logic [12:0] FIM_BIT  = 13'(CLOKS_POR_BIT - 1);

    logic        r_sync1;
    logic        r_sync2;

    estado_t     r_estado;
    logic [12:0] r_contador;
    logic [3:0]  r_indice;
    logic [15:0] r_desloc;
    logic [15:0] r_dados;
    logic        r_prontos;
    logic        r_recepcao;
    logic        r_erro;

    estado_t     w_estado_prox;
    logic [12:0] w_contador_prox;
    logic [3:0]  w_indice_prox;
    logic [15:0] w_desloc_prox;
    logic [15:0] w_dados_prox;
    logic        w_prontos_prox;
    logic        w_recepcao_prox;
    logic        w_erro_prox;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the old values on the
            // same edge; blocking here would collapse the chain into a single flop.
            r_sync1 <= bitSerialEntrada;
            r_sync2 <= r_sync1;
        end
    end

    // State register and datapath registers, all loaded from the next-state logic.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado   <= ESPERA;
            r_contador <= '0;
            r_indice   <= '0;
            r_desloc   <= '0;
            r_dados    <= '0;
            r_prontos  <= 1'b0;
            r_recepcao <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_contador <= w_contador_prox;
            r_indice   <= w_indice_prox;
            r_desloc   <= w_desloc_prox;
            r_dados    <= w_dados_prox;
            r_prontos  <= w_prontos_prox;
            r_recepcao <= w_recepcao_prox;
            r_erro     <= w_erro_prox;
        end
    end

    // Next-state and next-datapath logic for the frame receiver.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_estado_prox   = r_estado;
        w_contador_prox = r_contador;
        w_indice_prox   = r_indice;
        w_desloc_prox   = r_desloc;
        w_dados_prox    = r_dados;
        w_prontos_prox  = 1'b0;
        w_recepcao_prox = r_recepcao;
        w_erro_prox     = 1'b0;

        case (r_estado)
            ESPERA: begin
                w_contador_prox = '0;
                w_indice_prox   = '0;
                if (!r_sync2) begin
                    w_estado_prox   = VERIFICA_INICIO;
                    w_recepcao_prox = 1'b1;
                end
            end

            VERIFICA_INICIO: begin
                if (r_contador == MEIO_BIT) begin
                    w_contador_prox = '0;
                    if (!r_sync2) begin
                        w_estado_prox = RECEBE_BITS;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch.
                        w_estado_prox   = ESPERA;
                        w_recepcao_prox = 1'b0;
                    end
                end else begin
                    w_contador_prox = r_contador + 13'd1;
                end
            end

            RECEBE_BITS: begin
                if (r_contador == FIM_BIT) begin
                    w_contador_prox         = '0;
                    w_desloc_prox[r_indice] = r_sync2;
                    if (r_indice == 4'd15) begin
                        w_indice_prox = '0;
                        w_estado_prox = VERIFICA_FINAL;
                    end else begin
                        w_indice_prox = r_indice + 4'd1;
                    end
                end else begin
                    w_contador_prox = r_contador + 13'd1;
                end
            end

            VERIFICA_FINAL: begin
                if (r_contador == FIM_BIT) begin
                    w_contador_prox = '0;
                    w_recepcao_prox = 1'b0;
                    w_estado_prox   = LIMPEZA;
                    if (r_sync2) begin
                        w_dados_prox   = r_desloc;
                        w_prontos_prox = 1'b1;
                    end else begin
                        w_erro_prox = 1'b1;
                    end
                end else begin
                    w_contador_prox = r_contador + 13'd1;
                end
            end

            LIMPEZA: begin
                // Wait for an idle-high line so a held-low break is not re-decoded.
                w_contador_prox = '0;
                if (r_sync2) begin
                    w_estado_prox = ESPERA;
                end
            end

            default: begin
                w_estado_prox   = ESPERA;
                w_contador_prox = '0;
                w_indice_prox   = '0;
                w_recepcao_prox = 1'b0;
            end
        endcase
    end

    assign dadosRecebidos = r_dados;
    assign dadosProntos   = r_prontos;
    assign indicaRecepcao = r_recepcao;
    assign erroDeQuadro   = r_erro;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios plus randomized frames for uart_rx, checked
// against a queue of expected frame outcomes built from what the bench sends.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        bitSerialEntrada;
    logic [15:0] dadosRecebidos;
    logic        dadosProntos;
    logic        indicaRecepcao;
    logic        erroDeQuadro;

    always #5 clock = ~clock;

    uart_rx #(.CLOKS_POR_BIT(CPB)) dut (
        .clock            (clock),
        .reset            (reset),
        .bitSerialEntrada (bitSerialEntrada),
        .dadosRecebidos   (dadosRecebidos),
        .dadosProntos     (dadosProntos),
        .indicaRecepcao   (indicaRecepcao),
        .erroDeQuadro     (erroDeQuadro)
    );

    typedef struct packed {
        logic        is_err;
        logic [15:0] data;
    } evento_t;

    evento_t     exp_q[$];
    logic [15:0] last_good = 16'h0000;
    logic        prev_pulse = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One serial bit period, optionally checking the busy flag at mid-bit.
    task automatic drive_bit(input logic b, input bit chk_busy);
        bitSerialEntrada = b;
        for (int c = 0; c < CPB; c++) begin
            @(negedge clock);
            if (chk_busy && c == CPB / 2) check("busy_mid_frame", indicaRecepcao, 1);
        end
    endtask

    task automatic idle(input int cycles);
        bitSerialEntrada = 1'b1;
        repeat (cycles) @(negedge clock);
    endtask

    // Behavioural transmitter: records the expected outcome, then drives the frame.
    task automatic send_frame(input logic [15:0] d, input logic stop_ok, input bit chk_busy);
        evento_t ev;
        ev.is_err = ~stop_ok;
        ev.data   = d;
        exp_q.push_back(ev);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive_bit(d[i], chk_busy);
        drive_bit(stop_ok, 1'b0);
    endtask

    // Outcome monitor: every pulse must match the next expected frame outcome.
    always @(negedge clock) begin
        evento_t ev;
        if (!reset) begin
            if (dadosProntos || erroDeQuadro) begin
                check("pulse_exclusive", {31'b0, dadosProntos & erroDeQuadro}, 0);
                check("pulse_not_repeated", {31'b0, prev_pulse}, 0);
                check("pulse_expected", {31'b0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("pulse_kind_err", {31'b0, erroDeQuadro}, {31'b0, ev.is_err});
                    if (!ev.is_err) last_good = ev.data;
                    check("dados_recebidos", {16'b0, dadosRecebidos}, {16'b0, last_good});
                end
            end
            prev_pulse = dadosProntos | erroDeQuadro;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_busy;
        logic [15:0] d;
        logic ok;

        reset = 1'b1;
        bitSerialEntrada = 1'b1;
        #1;
        check("reset_dados", {16'b0, dadosRecebidos}, 0);
        check("reset_prontos", {31'b0, dadosProntos}, 0);
        check("reset_recepcao", {31'b0, indicaRecepcao}, 0);
        check("reset_erro", {31'b0, erroDeQuadro}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(2 * CPB);

        // Plain frame, busy checked through every data bit.
        send_frame(16'hA55A, 1'b1, 1'b1);
        idle(2 * CPB);
        check("a55a_received", {16'b0, dadosRecebidos}, 32'hA55A);
        check("a55a_idle_not_busy", {31'b0, indicaRecepcao}, 0);

        // Short low glitch: busy rises then falls, nothing reported.
        bitSerialEntrada = 1'b0;
        repeat (2) @(negedge clock);
        bitSerialEntrada = 1'b1;
        saw_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (indicaRecepcao) saw_busy = 1'b1;
        end
        check("glitch_busy_rose", {31'b0, saw_busy}, 1);
        check("glitch_busy_fell", {31'b0, indicaRecepcao}, 0);
        send_frame(16'h00FF, 1'b1, 1'b0);
        idle(2 * CPB);
        check("00ff_received", {16'b0, dadosRecebidos}, 32'h00FF);

        // Bad stop bit followed by a held-low line.
        send_frame(16'h1234, 1'b0, 1'b0);
        bitSerialEntrada = 1'b0;
        repeat (40) @(negedge clock);
        check("break_not_busy", {31'b0, indicaRecepcao}, 0);
        check("break_keeps_dados", {16'b0, dadosRecebidos}, 32'h00FF);
        idle(2 * CPB);

        // Back-to-back frames with a single stop bit and no idle gap.
        send_frame(16'h0001, 1'b1, 1'b0);
        send_frame(16'hFFFF, 1'b1, 1'b0);
        idle(2 * CPB);
        check("b2b_last", {16'b0, dadosRecebidos}, 32'hFFFF);

        // Reset during data bit 7 aborts the frame.
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive_bit(1'b1, 1'b0);
        bitSerialEntrada = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        #3 reset = 1'b1;
        #1;
        check("midreset_dados", {16'b0, dadosRecebidos}, 0);
        check("midreset_prontos", {31'b0, dadosProntos}, 0);
        check("midreset_recepcao", {31'b0, indicaRecepcao}, 0);
        check("midreset_erro", {31'b0, erroDeQuadro}, 0);
        last_good = 16'h0000;
        bitSerialEntrada = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(2 * CPB);
        send_frame(16'hC3C3, 1'b1, 1'b0);
        idle(2 * CPB);
        check("c3c3_received", {16'b0, dadosRecebidos}, 32'hC3C3);

        // Loopback-style word from a transmitter at the same bit rate.
        send_frame(16'hBEEF, 1'b1, 1'b0);
        idle(2 * CPB);
        check("beef_received", {16'b0, dadosRecebidos}, 32'hBEEF);

        // Randomized frames, gaps and stop-bit errors.
        for (int n = 0; n < 30; n++) begin
            d  = 16'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(d, ok, 1'b0);
            if (!ok) begin
                bitSerialEntrada = 1'b0;
                repeat ($urandom_range(0, 30)) @(negedge clock);
                idle(CPB);
            end
            idle($urandom_range(0, 20));
        end

        idle(3 * CPB);
        check("queue_drained", exp_q.size(), 0);
        check("final_not_busy", {31'b0, indicaRecepcao}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
